// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared defaults and width helpers for the reservation station
package rs_pkg;

  localparam int RS_DEPTH   = 16;
  localparam int RS_NUM_FU  = 3;
  localparam int RS_NUM_CDB = 2;
  localparam int RS_DATA_W  = 32;
  localparam int RS_PREG_W  = 6;
  localparam int RS_ROB_W   = 6;
  localparam int RS_CTRL_W  = 4;

  // Index width that stays at least one bit wide for single-element sets.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_select.sv
// rtl/rs_select.sv - priority picker: lowest requesting index, or oldest when AGE_EN
module rs_select
  import rs_pkg::*;
#(
  parameter int N      = 16,
  parameter int AGE_W  = 4,
  parameter bit AGE_EN = 1'b0,
  localparam int IDX_W = id_w(N)
) (
  input  logic [N-1:0]       req,
  input  logic [N*AGE_W-1:0] age,
  output logic [N-1:0]       grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [AGE_W-1:0] best;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    best  = '0;
    // strict greater-than keeps ties on the lowest index
    for (int i = 0; i < N; i++) begin
      if (req[i] && (!found || (AGE_EN && (age[i*AGE_W +: AGE_W] > best)))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
        best  = age[i*AGE_W +: AGE_W];
      end
    end
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - reservation station with CDB wakeup and per-FU issue
// Optional oldest-first select is enabled with macro RS_AGE_SELECT_EN.
module rs_issue_queue
  import rs_pkg::*;
#(
  parameter int DEPTH   = RS_DEPTH,
  parameter int NUM_FU  = RS_NUM_FU,
  parameter int NUM_CDB = RS_NUM_CDB,
  parameter int DATA_W  = RS_DATA_W,
  parameter int PREG_W  = RS_PREG_W,
  parameter int ROB_W   = RS_ROB_W,
  parameter int CTRL_W  = RS_CTRL_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [CTRL_W-1:0]           disp_ctrl,
  input  logic [PREG_W-1:0]           disp_prd,
  input  logic [PREG_W-1:0]           disp_prs1,
  input  logic [PREG_W-1:0]           disp_prs2,
  input  logic                        disp_rs1_rdy,
  input  logic                        disp_rs2_rdy,
  input  logic [DATA_W-1:0]           disp_rs1_val,
  input  logic [DATA_W-1:0]           disp_rs2_val,
  input  logic [DATA_W-1:0]           disp_imm,
  input  logic                        disp_alusrc,
  input  logic [ROB_W-1:0]            disp_rob,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*PREG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  input  logic [NUM_FU-1:0]           fu_ready,
  output logic [NUM_FU-1:0]           iss_valid,
  output logic [NUM_FU*CTRL_W-1:0]    iss_ctrl,
  output logic [NUM_FU*DATA_W-1:0]    iss_src1,
  output logic [NUM_FU*DATA_W-1:0]    iss_src2,
  output logic [NUM_FU*PREG_W-1:0]    iss_prd,
  output logic [NUM_FU*ROB_W-1:0]     iss_rob,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty
);

  localparam int IDX_W = id_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int FU_W  = id_w(NUM_FU);
  localparam int AGE_W = IDX_W;
`ifdef RS_AGE_SELECT_EN
  localparam bit AGE_EN = 1'b1;
`else
  localparam bit AGE_EN = 1'b0;
`endif

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic              rdy1;
    logic              rdy2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [ROB_W-1:0]  rob;
    logic [FU_W-1:0]   fu;
  } entry_t;

  entry_t             ent   [DEPTH];
  entry_t             ent_n [DEPTH];
  logic [FU_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]   free_idx;
  logic               accept;
  logic               byp1_rdy, byp2_rdy;
  logic [DATA_W-1:0]  byp1_val, byp2_val;
  logic [DEPTH-1:0]   req     [NUM_FU];
  logic [DEPTH-1:0]   grant   [NUM_FU];
  logic [IDX_W-1:0]   sel_idx [NUM_FU];
  logic [NUM_FU-1:0]  sel_found;
  logic [CNT_W-1:0]   num_iss;
  logic [DEPTH*AGE_W-1:0] age_flat;

  // disp_ready follows registered count, so a slot freed this cycle is not reused until next
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign disp_ready = !full;
  assign accept     = disp_valid && disp_ready && !flush;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!ent[i].valid) free_idx = IDX_W'(i);
  end

  // Same-cycle CDB capture for operands that arrive not ready; lowest port wins.
  always_comb begin
    byp1_rdy = disp_rs1_rdy;
    byp1_val = disp_rs1_val;
    byp2_rdy = disp_rs2_rdy || disp_alusrc;
    byp2_val = disp_alusrc ? disp_imm : disp_rs2_val;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (!(disp_rs1_rdy) && cdb_valid[k] && (cdb_tag[k*PREG_W +: PREG_W] == disp_prs1)) begin
        byp1_rdy = 1'b1;
        byp1_val = cdb_data[k*DATA_W +: DATA_W];
      end
      if (!(disp_rs2_rdy || disp_alusrc) && cdb_valid[k] &&
          (cdb_tag[k*PREG_W +: PREG_W] == disp_prs2)) begin
        byp2_rdy = 1'b1;
        byp2_val = cdb_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FU; f++)
      for (int i = 0; i < DEPTH; i++)
        req[f][i] = ent[i].valid && ent[i].rdy1 && ent[i].rdy2 &&
                    (ent[i].fu == FU_W'(f)) && fu_ready[f] && !flush;
  end

`ifdef RS_AGE_SELECT_EN
  logic [AGE_W-1:0] age [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) age_flat[i*AGE_W +: AGE_W] = age[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (IDX_W'(i) == free_idx) age[i] <= '0;
        else if (ent[i].valid && (age[i] != '1)) age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  assign age_flat = '0;
`endif

  for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
    rs_select #(.N(DEPTH), .AGE_W(AGE_W), .AGE_EN(AGE_EN)) u_sel (
      .req   (req[f]),
      .age   (age_flat),
      .grant (grant[f]),
      .idx   (sel_idx[f]),
      .found (sel_found[f])
    );
  end

  always_comb begin
    num_iss = '0;
    for (int f = 0; f < NUM_FU; f++) num_iss = num_iss + CNT_W'(sel_found[f]);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_n[i] = ent[i];
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (ent[i].valid && !ent[i].rdy1 && cdb_valid[k] &&
            (cdb_tag[k*PREG_W +: PREG_W] == ent[i].prs1)) begin
          ent_n[i].rdy1 = 1'b1;
          ent_n[i].val1 = cdb_data[k*DATA_W +: DATA_W];
        end
        if (ent[i].valid && !ent[i].rdy2 && cdb_valid[k] &&
            (cdb_tag[k*PREG_W +: PREG_W] == ent[i].prs2)) begin
          ent_n[i].rdy2 = 1'b1;
          ent_n[i].val2 = cdb_data[k*DATA_W +: DATA_W];
        end
      end
    end
    for (int f = 0; f < NUM_FU; f++)
      for (int i = 0; i < DEPTH; i++)
        if (grant[f][i]) ent_n[i].valid = 1'b0;
    if (accept) begin
      ent_n[free_idx].valid = 1'b1;
      ent_n[free_idx].ctrl  = disp_ctrl;
      ent_n[free_idx].prd   = disp_prd;
      ent_n[free_idx].prs1  = disp_prs1;
      ent_n[free_idx].prs2  = disp_prs2;
      ent_n[free_idx].rdy1  = byp1_rdy;
      ent_n[free_idx].rdy2  = byp2_rdy;
      ent_n[free_idx].val1  = byp1_val;
      ent_n[free_idx].val2  = byp2_val;
      ent_n[free_idx].rob   = disp_rob;
      ent_n[free_idx].fu    = rr_ptr;
    end
    if (flush)
      for (int i = 0; i < DEPTH; i++) ent_n[i].valid = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count     <= '0;
      rr_ptr    <= '0;
      iss_valid <= '0;
      iss_ctrl  <= '0;
      iss_src1  <= '0;
      iss_src2  <= '0;
      iss_prd   <= '0;
      iss_rob   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_n[i];
      count <= flush ? '0 : (count + CNT_W'(accept) - num_iss);
      if (flush) rr_ptr <= '0;
      else if (accept) rr_ptr <= (rr_ptr == FU_W'(NUM_FU - 1)) ? '0 : rr_ptr + 1'b1;
      iss_valid <= sel_found;
      for (int f = 0; f < NUM_FU; f++) begin
        if (sel_found[f]) begin
          iss_ctrl[f*CTRL_W +: CTRL_W] <= ent[sel_idx[f]].ctrl;
          iss_src1[f*DATA_W +: DATA_W] <= ent[sel_idx[f]].val1;
          iss_src2[f*DATA_W +: DATA_W] <= ent[sel_idx[f]].val2;
          iss_prd[f*PREG_W +: PREG_W]  <= ent[sel_idx[f]].prd;
          iss_rob[f*ROB_W +: ROB_W]    <= ent[sel_idx[f]].rob;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb/tb_rs_issue_queue.sv - directed self-checking bench for rs_issue_queue
module tb_rs_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_ctrl;
  logic [5:0]  disp_prd, disp_prs1, disp_prs2;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_rs1_val, disp_rs2_val, disp_imm;
  logic        disp_alusrc;
  logic [5:0]  disp_rob;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [63:0] cdb_data;
  logic [2:0]  fu_ready;
  logic [2:0]  iss_valid;
  logic [11:0] iss_ctrl;
  logic [95:0] iss_src1, iss_src2;
  logic [17:0] iss_prd, iss_rob;
  logic [4:0]  count;
  logic        full, empty;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_first, exp_second;

  rs_issue_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ctrl(disp_ctrl),
    .disp_prd(disp_prd), .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_imm(disp_imm), .disp_alusrc(disp_alusrc), .disp_rob(disp_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_ready(fu_ready), .iss_valid(iss_valid), .iss_ctrl(iss_ctrl),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_prd(iss_prd), .iss_rob(iss_rob),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] prs1, input logic r1, input logic [31:0] v1,
                      input logic [5:0] prs2, input logic r2, input logic [31:0] v2,
                      input logic alusrc, input logic [31:0] imm, input logic [5:0] rob);
    disp_valid   = 1'b1;
    disp_ctrl    = rob[3:0];
    disp_prd     = rob;
    disp_prs1    = prs1;
    disp_rs1_rdy = r1;
    disp_rs1_val = v1;
    disp_prs2    = prs2;
    disp_rs2_rdy = r2;
    disp_rs2_val = v2;
    disp_alusrc  = alusrc;
    disp_imm     = imm;
    disp_rob     = rob;
  endtask

  task automatic disp_rdy(input logic [31:0] v1, input logic [31:0] v2, input logic [5:0] rob);
    disp(6'd0, 1'b1, v1, 6'd0, 1'b1, v2, 1'b0, 32'd0, rob);
  endtask

  task automatic idle();
    disp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; idle();
    disp_ctrl = '0; disp_prd = '0; disp_prs1 = '0; disp_prs2 = '0;
    disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_val = '0; disp_rs2_val = '0;
    disp_imm = '0; disp_alusrc = 1'b0; disp_rob = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; fu_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", disp_ready, 1);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_iss_src1", iss_src1, 0);
    reset = 1'b0;

    // three ready dispatches, round-robin FU0/FU1/FU2
    fu_ready = 3'b111;
    disp_rdy(32'h11, 32'h21, 6'd1); tick();
    disp_rdy(32'h12, 32'h22, 6'd2); tick();
    disp_rdy(32'h13, 32'h23, 6'd3);
    check("rr_iss0", iss_valid, 3'b001);
    check("rr_src1_fu0", iss_src1[31:0], 32'h11);
    check("rr_count_a", count, 1);
    tick(); idle();
    check("rr_iss1", iss_valid, 3'b010);
    check("rr_src2_fu1", iss_src2[63:32], 32'h22);
    check("rr_count_b", count, 1);
    tick();
    check("rr_iss2", iss_valid, 3'b100);
    check("rr_rob_fu2", iss_rob[17:12], 6'd3);
    check("rr_count_c", count, 0);
    check("rr_empty", empty, 1);
    tick();
    check("rr_pulse_end", iss_valid, 3'b000);

    // CDB wakeup three cycles after dispatch
    disp(6'd5, 1'b0, 32'h0, 6'd0, 1'b1, 32'h7, 1'b0, 32'd0, 6'd4); tick();
    idle(); tick(); tick();
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd5}; cdb_data = {32'h0, 32'hDEADBEEF};
    tick();
    cdb_valid = 2'b00;
    check("wk_not_yet", iss_valid, 3'b000);
    tick();
    check("wk_iss", iss_valid, 3'b001);
    check("wk_src1", iss_src1[31:0], 32'hDEADBEEF);
    check("wk_src2", iss_src2[31:0], 32'h7);
    check("wk_prd", iss_prd[5:0], 6'd4);

    // same-cycle bypass from CDB port 1 (goes to FU1)
    disp(6'd0, 1'b1, 32'h55, 6'd9, 1'b0, 32'h0, 1'b0, 32'd0, 6'd5);
    cdb_valid = 2'b10; cdb_tag = {6'd9, 6'd0}; cdb_data = {32'h1234, 32'h0};
    tick();
    idle(); cdb_valid = 2'b00;
    tick();
    check("byp_iss", iss_valid, 3'b010);
    check("byp_src2", iss_src2[63:32], 32'h1234);
    check("byp_src1", iss_src1[63:32], 32'h55);

    // alusrc forces src2 ready with the immediate (goes to FU2)
    disp(6'd0, 1'b1, 32'h1, 6'd12, 1'b0, 32'hFFFF, 1'b1, 32'hABC, 6'd6); tick();
    idle(); tick();
    check("imm_iss", iss_valid, 3'b100);
    check("imm_src2", iss_src2[95:64], 32'hABC);

    // fill all entries with issue blocked
    fu_ready = 3'b000;
    for (int i = 0; i < 16; i++) begin
      disp_rdy(32'(i), 32'(i), 6'(16 + i));
      tick();
    end
    disp_rdy(32'h0, 32'h0, 6'h3F);
    check("fill_full", full, 1);
    check("fill_ready", disp_ready, 0);
    check("fill_count", count, 16);
    tick();
    idle();
    check("fill_ignored", count, 16);
    fu_ready = 3'b001;
    tick();
    fu_ready = 3'b000;
    check("fill_full_drop", full, 0);
    check("fill_ready_back", disp_ready, 1);
    check("fill_count_dec", count, 15);
    check("fill_iss", iss_valid, 3'b001);
    check("fill_iss_rob", iss_rob[5:0], 6'h10);

    // flush the full queue, refill five, then flush with a concurrent dispatch
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl1_count", count, 0);
    for (int i = 0; i < 5; i++) begin
      disp_rdy(32'h0, 32'h0, 6'(32 + i));
      tick();
    end
    idle();
    check("fl2_pre_count", count, 5);
    flush = 1'b1; fu_ready = 3'b111;
    disp_rdy(32'h0, 32'h0, 6'h25);
    tick();
    flush = 1'b0; idle();
    check("fl2_count", count, 0);
    check("fl2_empty", empty, 1);
    check("fl2_no_iss", iss_valid, 3'b000);
    tick(); tick();
    check("fl2_no_iss_late", iss_valid, 3'b000);

    // rr_ptr was cleared by flush, so the next dispatch targets FU0
    disp_rdy(32'h77, 32'h0, 6'h2A); tick();
    idle(); tick();
    check("fl_rr_iss", iss_valid, 3'b001);
    check("fl_rr_rob", iss_rob[5:0], 6'h2A);
    flush = 1'b1; fu_ready = 3'b000; tick(); flush = 1'b0;

    // two FU0 waiters woken together: older one sits at the higher index
    disp_rdy(32'h0, 32'h0, 6'h30); tick();
    disp_rdy(32'h0, 32'h0, 6'h31); tick();
    disp_rdy(32'h0, 32'h0, 6'h32); tick();
    disp(6'd7, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 1'b0, 32'd0, 6'h33); tick();
    disp_rdy(32'h0, 32'h0, 6'h34); tick();
    disp_rdy(32'h0, 32'h0, 6'h35); tick();
    idle(); fu_ready = 3'b001; tick();
    fu_ready = 3'b000;
    check("age_pre_iss", iss_rob[5:0], 6'h30);
    disp(6'd7, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 1'b0, 32'd0, 6'h36); tick();
    idle();
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd7}; cdb_data = {32'h0, 32'h99};
    fu_ready = 3'b001;
    tick();
    cdb_valid = 2'b00;
    tick();
`ifdef RS_AGE_SELECT_EN
    exp_first = 6'h33; exp_second = 6'h36;
`else
    exp_first = 6'h36; exp_second = 6'h33;
`endif
    check("sel_first_v", iss_valid, 3'b001);
    check("sel_first_rob", iss_rob[5:0], exp_first);
    tick();
    check("sel_second_v", iss_valid, 3'b001);
    check("sel_second_rob", iss_rob[5:0], exp_second);
    check("sel_second_src1", iss_src1[31:0], 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
